// File: rtl/ahb_sram_ws.sv
// ahb_sram_ws - AHB-Lite SRAM slave with configurable depth, programmable
// wait states and an ERROR response for illegal transfers.
//
// Parameters
//   MEM_AW          byte-address width, capacity 2^MEM_AW bytes (10..20)
//   WAIT_STATES     extra data-phase cycles for OKAY transfers (0..7)
//   ERR_ON_MISALIGN 1: misaligned half/word -> ERROR; 0: aligned down, OKAY
//
// Ports
//   HCLK, HRESETn   clock (rising edge), asynchronous active-low reset
//   HSEL, HREADY    decoder select, bus ready (address phase sampled when 1)
//   HADDR           byte address, bits [MEM_AW-1:0] used (array aliases)
//   HTRANS, HWRITE  transfer type, write flag
//   HSIZE           0 byte, 1 half, 2 word; 3..7 illegal
//   HWDATA          write data, stable for the whole data phase
//   HREADYOUT       slave ready
//   HRESP           0 OKAY, 1 ERROR
//   HRDATA          read data, valid only in the final data-phase cycle

module ahb_sram_ws #(
    parameter int MEM_AW          = 16,
    parameter int WAIT_STATES     = 0,
    parameter bit ERR_ON_MISALIGN = 1'b1
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic        HREADY,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA
);

    localparam int         DEPTH   = 2 ** (MEM_AW - 2);
    localparam logic [2:0] WS_LOAD = 3'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    typedef enum logic [2:0] {
        ST_IDLE,   // no data phase of ours in progress (or zero-wait idle)
        ST_WAIT,   // OKAY transfer, HREADYOUT low
        ST_LAST,   // final data-phase cycle of an OKAY transfer
        ST_ERR1,   // ERROR cycle 1: HREADYOUT low
        ST_ERR2    // ERROR cycle 2: HREADYOUT high
    } state_t;

    state_t              state;
    logic [MEM_AW-1:0]   a_addr;
    logic                a_write;
    logic [1:0]          a_size;
    logic [2:0]          wait_cnt;
    logic                hreadyout_q;
    logic                hresp_q;
    logic                rd_valid;

    logic [31:0]         mem [DEPTH];
    logic [31:0]         rd_q;

    logic                active;
    logic                illegal;
    logic [3:0]          byte_en;
    logic [MEM_AW-3:0]   wr_idx;
    logic [MEM_AW-3:0]   rd_idx;
    logic                unused_ok;

    assign unused_ok = ^{HADDR[31:MEM_AW], HTRANS[0]};

    function automatic logic [3:0] lanes(input logic [1:0] sz, input logic [1:0] off);
        case (sz)
            2'd0:    lanes = 4'b0001 << off;
            2'd1:    lanes = off[1] ? 4'b1100 : 4'b0011;
            default: lanes = 4'b1111;
        endcase
    endfunction

    assign active  = HSEL & HTRANS[1];
    assign illegal = (HSIZE > 3'd2) ||
                     (ERR_ON_MISALIGN &&
                      (((HSIZE == 3'd1) && HADDR[0]) ||
                       ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00))));

    // Writes commit on the edge that ends the final data-phase cycle.
    assign byte_en = (state == ST_LAST && a_write) ? lanes(a_size, a_addr[1:0]) : '0;
    assign wr_idx  = a_addr[MEM_AW-1:2];

    // The read port is clocked on the edge that opens the final data-phase
    // cycle: the capture edge for zero-wait reads (live HADDR), or the edge
    // leaving the last wait cycle (captured address).
    assign rd_idx  = (state == ST_WAIT) ? a_addr[MEM_AW-1:2] : HADDR[MEM_AW-1:2];

    always_ff @(posedge HCLK) begin
        for (int unsigned i = 0; i < 4; i++) begin
            if (byte_en[i]) begin
                mem[wr_idx][8*i +: 8] <= HWDATA[8*i +: 8];
            end
        end
    end

    // A write committing on the same edge as the read is forwarded lane by
    // lane, so a back-to-back read of the same word never sees stale bytes.
    always_ff @(posedge HCLK) begin
        for (int unsigned i = 0; i < 4; i++) begin
            rd_q[8*i +: 8] <= (byte_en[i] && (wr_idx == rd_idx)) ? HWDATA[8*i +: 8]
                                                                  : mem[rd_idx][8*i +: 8];
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state       <= ST_IDLE;
            a_addr      <= '0;
            a_write     <= 1'b0;
            a_size      <= '0;
            wait_cnt    <= '0;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
            rd_valid    <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            case (state)
                ST_ERR1: begin
                    state       <= ST_ERR2;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= 1'b1;
                end
                ST_WAIT: begin
                    if (wait_cnt == '0) begin
                        state       <= ST_LAST;
                        hreadyout_q <= 1'b1;
                        rd_valid    <= !a_write;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                default: begin
                    if (HREADY && active) begin
                        if (illegal) begin
                            state       <= ST_ERR1;
                            hreadyout_q <= 1'b0;
                            hresp_q     <= 1'b1;
                        end else begin
                            a_addr  <= HADDR[MEM_AW-1:0];
                            a_write <= HWRITE;
                            a_size  <= HSIZE[1:0];
                            hresp_q <= 1'b0;
                            if (WAIT_STATES == 0) begin
                                state       <= ST_LAST;
                                hreadyout_q <= 1'b1;
                                rd_valid    <= !HWRITE;
                            end else begin
                                state       <= ST_WAIT;
                                hreadyout_q <= 1'b0;
                                wait_cnt    <= WS_LOAD;
                            end
                        end
                    end else begin
                        state       <= ST_IDLE;
                        hreadyout_q <= 1'b1;
                        hresp_q     <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign HREADYOUT = hreadyout_q;
    assign HRESP     = hresp_q;
    assign HRDATA    = rd_valid ? rd_q : '0;

endmodule

// File: tb/tb_ahb_sram_ws.sv
// Self-checking bench for ahb_sram_ws. Three instances run side by side:
//   cfg0: WAIT_STATES=0, ERR_ON_MISALIGN=1
//   cfg1: WAIT_STATES=3, ERR_ON_MISALIGN=1
//   cfg2: WAIT_STATES=0, ERR_ON_MISALIGN=0
// Each has a byte-array memory model that turns every accepted address phase
// into the list of per-cycle outputs it must produce, plus directed checks
// with hand-computed literal values.

module tb_ahb_sram_ws;

    localparam int AW = 12;

    typedef struct {
        bit          rdy;
        bit          resp;
        logic [31:0] data;
        bit          commit;
        logic [31:0] addr;
        logic [2:0]  size;
    } exp_t;

    logic HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    int checks = 0;
    int errors = 0;
    int done   = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input bit rdy, input bit resp, input logic [31:0] data,
                                input bit commit, input logic [31:0] addr, input logic [2:0] size);
        exp_t e;
        e.rdy = rdy; e.resp = resp; e.data = data;
        e.commit = commit; e.addr = addr; e.size = size;
        return e;
    endfunction

    // Preamble contents of word i.
    function automatic logic [31:0] pre(input int i);
        return {8'(i) ^ 8'h5A, 8'h3C, 8'(i), 8'hC3};
    endfunction

    // Does byte k of the aligned word belong to a transfer of size sz at addr?
    function automatic bit byte_hit(input logic [2:0] sz, input logic [31:0] addr, input int k);
        if (sz == 3'd0) return (k == int'(addr[1:0]));
        if (sz == 3'd1) return ((k / 2) == int'(addr[1]));
        return 1'b1;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : cfg
        localparam int WS = (g == 1) ? 3 : 0;
        localparam bit EM = (g == 2) ? 1'b0 : 1'b1;

        logic        rst_n = 1'b1;
        logic        hsel, hwrite, hreadyout, hresp;
        logic [1:0]  htrans;
        logic [2:0]  hsize;
        logic [31:0] haddr, hwdata, hrdata;
        logic [31:0] pend_wd;

        exp_t        q[$];
        logic [7:0]  mm [2**AW];

        ahb_sram_ws #(
            .MEM_AW(AW),
            .WAIT_STATES(WS),
            .ERR_ON_MISALIGN(EM)
        ) dut (
            .HCLK(HCLK),
            .HRESETn(rst_n),
            .HSEL(hsel),
            .HREADY(hreadyout),
            .HADDR(haddr),
            .HTRANS(htrans),
            .HWRITE(hwrite),
            .HSIZE(hsize),
            .HWDATA(hwdata),
            .HREADYOUT(hreadyout),
            .HRESP(hresp),
            .HRDATA(hrdata)
        );

        // Model: the queue front is the expectation for the current cycle.
        always @(negedge rst_n) q.delete();

        always @(posedge HCLK) begin
            exp_t        e;
            bit          take;
            bit          bad;
            logic [31:0] base;
            if (rst_n === 1'b1) begin
                take = 1'b1;
                if (q.size() != 0) begin
                    e    = q.pop_front();
                    take = e.rdy;
                    if (e.commit) begin
                        base = e.addr & 32'((1 << AW) - 1) & ~32'd3;
                        for (int k = 0; k < 4; k++)
                            if (byte_hit(e.size, e.addr, k)) mm[base + 32'(k)] = hwdata[8*k +: 8];
                    end
                end
                if (take) begin
                    if (!(hsel && htrans[1])) begin
                        q.push_back(mk(1'b1, 1'b0, '0, 1'b0, '0, '0));
                    end else begin
                        bad = (hsize > 3'd2) ||
                              (EM && ((hsize == 3'd1 && haddr[0]) ||
                                      (hsize == 3'd2 && haddr[1:0] != 2'b00)));
                        if (bad) begin
                            q.push_back(mk(1'b0, 1'b1, '0, 1'b0, '0, '0));
                            q.push_back(mk(1'b1, 1'b1, '0, 1'b0, '0, '0));
                        end else begin
                            for (int w = 0; w < WS; w++) q.push_back(mk(1'b0, 1'b0, '0, 1'b0, '0, '0));
                            base = haddr & 32'((1 << AW) - 1) & ~32'd3;
                            q.push_back(mk(1'b1, 1'b0,
                                           hwrite ? 32'd0 : {mm[base+3], mm[base+2], mm[base+1], mm[base]},
                                           hwrite, haddr, hsize));
                        end
                    end
                end
            end
        end

        // Compare process: every cycle, away from the active edge.
        always @(negedge HCLK) begin
            exp_t e;
            if (rst_n !== 1'b1)    e = mk(1'b1, 1'b0, '0, 1'b0, '0, '0);
            else if (q.size() == 0) e = mk(1'b1, 1'b0, '0, 1'b0, '0, '0);
            else                    e = q[0];
            check32($sformatf("cfg%0d HREADYOUT", g), {31'b0, hreadyout}, {31'b0, e.rdy});
            check32($sformatf("cfg%0d HRESP", g),     {31'b0, hresp},     {31'b0, e.resp});
            check32($sformatf("cfg%0d HRDATA", g),    hrdata,             e.data);
        end

        // One address phase; returns observations of the data phase it
        // overlaps (i.e. the previous transfer's data phase).
        task automatic xfer(input bit act, input bit wr, input logic [2:0] sz,
                            input logic [31:0] addr, input logic [31:0] wd,
                            output int cyc, output bit saw_resp, output logic [31:0] rd);
            bit rdy;
            if (act) begin
                hsel   = 1'b1;
                htrans = ($urandom_range(1) != 0) ? 2'b11 : 2'b10;
            end else begin
                case ($urandom_range(2))
                    0:       begin hsel = 1'b0; htrans = 2'($urandom_range(3)); end
                    1:       begin hsel = 1'b1; htrans = 2'b00; end
                    default: begin hsel = 1'b1; htrans = 2'b01; end
                endcase
            end
            hwrite   = wr;
            hsize    = sz;
            haddr    = addr;
            hwdata   = pend_wd;
            pend_wd  = wd;
            cyc      = 0;
            saw_resp = 1'b0;
            rd       = '0;
            rdy      = 1'b0;
            do begin
                @(negedge HCLK);
                cyc++;
                saw_resp = saw_resp | hresp;
                rd       = hrdata;
                rdy      = hreadyout;
                @(posedge HCLK);
                #1;
            end while (!rdy && cyc < 20);
            check32($sformatf("cfg%0d ready within bound", g), {31'b0, rdy}, 32'd1);
        endtask

        initial begin : stim
            int          c;
            bit          r;
            logic [31:0] d;
            bit          act, wr;
            logic [2:0]  sz;
            logic [31:0] ad;

            hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'd0;
            haddr = '0; hwdata = '0; pend_wd = '0;
            #1 rst_n = 1'b0;
            repeat (2) @(posedge HCLK);
            @(negedge HCLK);
            rst_n = 1'b1;
            @(posedge HCLK);
            #1;

            for (int i = 0; i < 32; i++)
                xfer(1'b1, 1'b1, 3'd2, ($urandom & 32'hFFFF_F000) | 32'(i * 4), pre(i), c, r, d);

            // Write then back-to-back read of the same word (aliased address).
            xfer(1'b1, 1'b1, 3'd2, 32'h0000_0010, 32'hDEADBEEF, c, r, d);
            xfer(1'b1, 1'b0, 3'd2, 32'hABCD_0010, 32'h0, c, r, d);
            check32($sformatf("cfg%0d write phase length", g), 32'(c), 32'(WS + 1));
            xfer(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, c, r, d);
            check32($sformatf("cfg%0d RAW read data", g), d, 32'hDEADBEEF);
            check32($sformatf("cfg%0d read phase length", g), 32'(c), 32'(WS + 1));
            xfer(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, c, r, d);
            check32($sformatf("cfg%0d idle zero-wait", g), 32'(c), 32'd1);

            // Byte lanes.
            xfer(1'b1, 1'b1, 3'd2, 32'h0000_0020, 32'h0000_0000, c, r, d);
            xfer(1'b1, 1'b1, 3'd0, 32'h0000_0021, 32'h0000_AA00, c, r, d);
            xfer(1'b1, 1'b1, 3'd1, 32'h0000_0022, 32'h1234_0000, c, r, d);
            xfer(1'b1, 1'b0, 3'd2, 32'h0000_0020, 32'h0, c, r, d);
            xfer(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, c, r, d);
            check32($sformatf("cfg%0d byte lanes", g), d, 32'h1234AA00);

            // Misaligned word write.
            xfer(1'b1, 1'b1, 3'd2, 32'h0000_0006, 32'hFFFF_FFFF, c, r, d);
            xfer(1'b1, 1'b0, 3'd2, 32'h0000_0004, 32'h0, c, r, d);
            check32($sformatf("cfg%0d misalign resp", g), {31'b0, r}, {31'b0, EM});
            check32($sformatf("cfg%0d misalign length", g), 32'(c), EM ? 32'd2 : 32'(WS + 1));
            xfer(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, c, r, d);
            check32($sformatf("cfg%0d misalign readback", g), d, EM ? 32'h5B3C01C3 : 32'hFFFF_FFFF);

            // HSIZE = 3 is always an ERROR.
            xfer(1'b1, 1'b0, 3'd3, 32'h8000_0044, 32'h0, c, r, d);
            xfer(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, c, r, d);
            check32($sformatf("cfg%0d hsize3 resp", g), {31'b0, r}, 32'd1);
            check32($sformatf("cfg%0d hsize3 length", g), 32'(c), 32'd2);
            check32($sformatf("cfg%0d hsize3 rdata", g), d, 32'h0);

            // Plain read of preamble word 2.
            xfer(1'b1, 1'b0, 3'd2, 32'h0000_0008, 32'h0, c, r, d);
            xfer(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, c, r, d);
            check32($sformatf("cfg%0d read length", g), 32'(c), 32'(WS + 1));
            check32($sformatf("cfg%0d read data", g), d, 32'h583C02C3);

            // Reset in the middle of a write data phase (2nd wait cycle when
            // there are wait states).
            xfer(1'b1, 1'b1, 3'd2, 32'h0000_0030, 32'h0BAD_F00D, c, r, d);
            hsel = 1'b0; htrans = 2'b00; hwdata = pend_wd;
            repeat ((WS >= 2) ? 1 : 0) begin @(posedge HCLK); #1; end
            @(negedge HCLK);
            #2 rst_n = 1'b0;
            #1;
            check32($sformatf("cfg%0d reset HREADYOUT", g), {31'b0, hreadyout}, 32'd1);
            check32($sformatf("cfg%0d reset HRESP", g),     {31'b0, hresp},     32'd0);
            check32($sformatf("cfg%0d reset HRDATA", g),    hrdata,             32'd0);
            repeat (2) @(posedge HCLK);
            @(negedge HCLK);
            rst_n   = 1'b1;
            pend_wd = '0;
            @(posedge HCLK);
            #1;
            xfer(1'b1, 1'b0, 3'd2, 32'h0000_0030, 32'h0, c, r, d);
            xfer(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, c, r, d);
            check32($sformatf("cfg%0d word unchanged after reset", g), d, 32'h563C0CC3);

            // Random traffic over the preamble region with aliased upper bits.
            for (int n = 0; n < 400; n++) begin
                act = ($urandom_range(3) != 0);
                wr  = ($urandom_range(1) != 0);
                sz  = ($urandom_range(9) == 0) ? 3'($urandom_range(7)) : 3'($urandom_range(2));
                ad  = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(127));
                xfer(act, wr, sz, ad, $urandom, c, r, d);
            end
            xfer(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, c, r, d);
            xfer(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, c, r, d);
            done++;
        end
    end

    initial begin : finish_blk
        for (int t = 0; t < 20000 && done < 3; t++) @(posedge HCLK);
        check32("all configs finished", 32'(done), 32'd3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb_sram_ws.md
Name: ahb_sram_ws

Overview:
- Parametrised AHB-Lite SRAM slave; next generation of the team's single-cycle on-chip memory block.
- Adds configurable memory depth, programmable wait states, an HRESP error response for illegal transfers, and a guarantee that a read returns data written by the immediately preceding transfer.
- Sits on the AHB-Lite interconnect behind the address decoder as main code/data RAM.

Parameters:
- MEM_AW, 16, byte-address width; capacity 2^MEM_AW bytes (16 = 64KB = 16K words); range 10..20.
- WAIT_STATES, 0, extra data-phase cycles for OKAY SEQ/NONSEQ transfers; range 0..7.
- ERR_ON_MISALIGN, 1, 1 = misaligned transfers get an ERROR response; 0 = address low bits ignored per HSIZE (aligned down), OKAY.

Ports:
- HCLK  in  1  clock; all logic on rising edge.
- HRESETn  in  1  asynchronous, active-low reset.
- HSEL  in  1  slave select from decoder.
- HREADY  in  1  bus ready; address phase is sampled only when 1.
- HADDR  in  32  byte address; bits [MEM_AW-1:0] are used.
- HTRANS  in  2  transfer type (IDLE/BUSY/NONSEQ/SEQ).
- HWRITE  in  1  1 = write.
- HSIZE  in  3  0 = byte, 1 = half, 2 = word; values 3..7 are illegal.
- HWDATA  in  32  write data, stable for the whole data phase.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0 = OKAY, 1 = ERROR.
- HRDATA  out  32  read data.

Behaviour:
- Reset, asynchronous:
  - HREADYOUT = 1, HRESP = 0, HRDATA = 0.
  - Address-phase registers cleared; any in-progress transfer is abandoned and no write is committed.
  - Memory contents are not reset.
- Address sampling: on a rising edge with HREADY = 1, capture HSEL, HTRANS, HWRITE, HSIZE and HADDR[MEM_AW-1:0]. An active transfer is HSEL & HTRANS[1].
- Inactive transfer (IDLE, BUSY, or unselected): zero-wait OKAY. HREADYOUT = 1, HRESP = 0, no memory access.
- Legality checks on the captured address phase:
  - HSIZE > 2 is always illegal.
  - When ERR_ON_MISALIGN = 1, a half with addr[0] = 1 is illegal, and a word with addr[1:0] != 0 is illegal.
- ERROR response (illegal active transfer); WAIT_STATES does not apply:
  - Cycle 1: HREADYOUT = 0, HRESP = 1.
  - Cycle 2: HREADYOUT = 1, HRESP = 1.
  - No memory write. HRDATA = 0.
  - A new address phase is sampled at the end of cycle 2 only, because HREADY is low in cycle 1.
  - A master that drives IDLE during cycle 1 gets a zero-wait OKAY for that IDLE.
- OKAY active transfer:
  - The data phase lasts 1 + WAIT_STATES cycles.
  - HREADYOUT = 0 for the first WAIT_STATES cycles, then 1. HRESP = 0 throughout.
  - A down-counter loaded at address capture controls the wait cycles.
- Read:
  - HRDATA carries the full 32-bit word at addr[MEM_AW-1:2] in the final data-phase cycle, i.e. the cycle with HREADYOUT = 1.
  - HRDATA = 0 in every other cycle, and for writes, idles and errors.
- Write:
  - Byte lanes are enabled by HSIZE and addr[1:0]:
    - word: lanes 3..0;
    - half at offset 0: lanes 1..0; half at offset 2: lanes 3..2;
    - byte: the single lane addr[1:0].
  - Enabled lanes take HWDATA; the other lanes are unchanged. Use a true per-byte write enable, not a read-modify-write merge.
  - The write commits on the rising edge that ends the final data-phase cycle.
- Read-after-write: a read whose address phase overlaps the data phase of a write to the same word returns the merged, newly written bytes. This is implemented by forwarding or by deferring the read; no stale data is allowed.
- Back-to-back transfers are pipelined: address phase N+1 overlaps data phase N. With WAIT_STATES = 0, throughput is one transfer per cycle.
- Wrap-around: address bits at and above MEM_AW are ignored, so the array aliases across HADDR.
- Behaviour is fully synchronous apart from reset. The memory is inferred as single-clock BRAM with separate read and write ports.

Test Plan:
- WAIT_STATES = 0:
  - Stimulus: word write 0xDEADBEEF to 0x0010, then back-to-back word read of 0x0010.
  - Required response: read returns 0xDEADBEEF in the very next data phase; HREADYOUT stays 1.
- Byte lanes:
  - Stimulus: after 0x00000000 at 0x0020, write byte 0xAA at 0x0021, write half 0x1234 at 0x0022, then read the word.
  - Required response: 0x1234AA00.
- WAIT_STATES = 3:
  - Stimulus: NONSEQ read.
  - Required response: HREADYOUT low for 3 cycles, high on the 4th with valid data. IDLE transfers still complete zero-wait.
- ERR_ON_MISALIGN = 1:
  - Stimulus: word write with data 0xFFFFFFFF to 0x0006.
  - Required response: HRESP = 1 for 2 cycles with HREADYOUT 0 then 1; a subsequent read of 0x0004 shows the word unchanged.
- HSIZE = 3, any address:
  - Required response: ERROR response.
- ERR_ON_MISALIGN = 0:
  - Stimulus: same word write, 0xFFFFFFFF to 0x0006.
  - Required response: OKAY, and 0xFFFFFFFF is written to 0x0004.
- Reset mid-operation:
  - Stimulus: assert HRESETn low during the 2nd wait cycle of a write with WAIT_STATES = 3.
  - Required response: outputs go to reset values immediately; the target word is unchanged after reset is released.
